// File: rtl/fifo_top.sv
// Single-clock synchronous FIFO with wrap-bit pointers and registered read data.
// Define FIFO_OVERFLOW_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_top #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_full,
    output logic                  read_empty,
`ifdef FIFO_OVERFLOW_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   fill_level
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  write_accept;
    logic                  read_accept;

    // Flags derive only from registered pointers, so no input reaches an output combinationally.
    assign read_empty   = (wr_ptr == rd_ptr);
    assign write_full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                          (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign fill_level   = wr_ptr - rd_ptr;
    assign write_accept = write_enable && !write_full;
    assign read_accept  = read_enable && !read_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (write_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            read_data <= '0;
        end else begin
            if (write_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_accept) begin
                read_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef FIFO_OVERFLOW_FLAGS_EN
    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable && write_full) begin
                overflow <= 1'b1;
            end
            if (read_enable && read_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_top.sv
// Self-checking bench for fifo_top using a queue-based reference model.
// Also exercises the sticky flags when FIFO_OVERFLOW_FLAGS_EN is defined.
module tb_fifo_top;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic                  clk;
    logic                  reset_n;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  write_full;
    logic                  read_empty;
    logic [ADDR_WIDTH:0]   fill_level;
`ifdef FIFO_OVERFLOW_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
    logic                  exp_ovf;
    logic                  exp_unf;
`endif

    logic [DATA_WIDTH-1:0] model_q [$];
    logic [DATA_WIDTH-1:0] exp_rd;
    int                    n_checks;
    int                    n_fail;

    fifo_top #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .write_full   (write_full),
        .read_empty   (read_empty),
`ifdef FIFO_OVERFLOW_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .fill_level   (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {read_empty, write_full, fill_level} from the model occupancy.
    function automatic logic [ADDR_WIDTH+2:0] model_status();
        int n;
        n = model_q.size();
        return {(n == 0), (n == DEPTH), (ADDR_WIDTH+1)'(n)};
    endfunction

    function automatic logic [ADDR_WIDTH+2:0] dut_status();
        return {read_empty, write_full, fill_level};
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_rd = '0;
`ifdef FIFO_OVERFLOW_FLAGS_EN
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
    endtask

    // Drive one cycle and advance the model using the occupancy seen before the edge.
    task automatic step(input logic we, input logic re, input logic [DATA_WIDTH-1:0] wd);
        bit wacc;
        bit racc;
        write_enable = we;
        read_enable  = re;
        write_data   = wd;
        @(posedge clk);
        wacc = we && (model_q.size() < DEPTH);
        racc = re && (model_q.size() > 0);
`ifdef FIFO_OVERFLOW_FLAGS_EN
        if (we && model_q.size() == DEPTH) exp_ovf = 1'b1;
        if (re && model_q.size() == 0) exp_unf = 1'b1;
`endif
        if (racc) exp_rd = model_q.pop_front();
        if (wacc) model_q.push_back(wd);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic test_reset();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = '0;
        reset_n      = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (dut_status() !== model_status()) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got %b expected %b", dut_status(), model_status());
        end
        n_checks++;
        if (read_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_read_data: got %h expected 00", read_data);
        end
`ifdef FIFO_OVERFLOW_FLAGS_EN
        n_checks++;
        if ({overflow, underflow} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_sticky: got %b expected 00", {overflow, underflow});
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DATA_WIDTH'(i));
            n_checks++;
            if (dut_status() !== model_status()) begin
                n_fail++;
                $display("[TB] FAIL fill_status[%0d]: got %b expected %b", i, dut_status(), model_status());
            end
        end
        n_checks++;
        if (!(write_full === 1'b1 && fill_level === 4'd8)) begin
            n_fail++;
            $display("[TB] FAIL fill_full: got full=%b level=%0d expected full=1 level=8", write_full, fill_level);
        end
`ifdef FIFO_OVERFLOW_FLAGS_EN
        n_checks++;
        if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fill_overflow: got %b expected 1", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (read_data !== DATA_WIDTH'((i < DEPTH) ? i : DEPTH - 1)) begin
                n_fail++;
                $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, read_data,
                         DATA_WIDTH'((i < DEPTH) ? i : DEPTH - 1));
            end
            n_checks++;
            if (dut_status() !== model_status()) begin
                n_fail++;
                $display("[TB] FAIL drain_status[%0d]: got %b expected %b", i, dut_status(), model_status());
            end
        end
`ifdef FIFO_OVERFLOW_FLAGS_EN
        n_checks++;
        if (underflow !== exp_unf || exp_unf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drain_underflow: got %b expected 1", underflow);
        end
`endif
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_WIDTH'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, DATA_WIDTH'(8'h40 + i));
            n_checks++;
            if (fill_level !== 4'd3 || read_data !== exp_rd) begin
                n_fail++;
                $display("[TB] FAIL simul_rw[%0d]: got level=%0d data=%h expected level=3 data=%h",
                         i, fill_level, read_data, exp_rd);
            end
        end
        while (model_q.size() < DEPTH) step(1'b1, 1'b0, DATA_WIDTH'($urandom));
        step(1'b1, 1'b1, 8'hEE);
        n_checks++;
        if (fill_level !== 4'd7 || write_full !== 1'b0 || read_data !== exp_rd) begin
            n_fail++;
            $display("[TB] FAIL simul_full: got level=%0d full=%b data=%h expected level=7 full=0 data=%h",
                     fill_level, write_full, read_data, exp_rd);
        end
        while (model_q.size() > 0) begin
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (read_data !== exp_rd) begin
                n_fail++;
                $display("[TB] FAIL simul_drain: got %h expected %h", read_data, exp_rd);
            end
        end
    endtask

    task automatic test_wraparound();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, DATA_WIDTH'(8'h10 + i));
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (read_data !== DATA_WIDTH'(8'h10 + i) || dut_status() !== model_status()) begin
                n_fail++;
                $display("[TB] FAIL wrap[%0d]: got data=%h status=%b expected data=%h status=%b",
                         i, read_data, dut_status(), DATA_WIDTH'(8'h10 + i), model_status());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), DATA_WIDTH'($urandom));
            n_checks++;
            if (read_data !== exp_rd || dut_status() !== model_status()) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got data=%h status=%b expected data=%h status=%b",
                         i, read_data, dut_status(), exp_rd, model_status());
            end
`ifdef FIFO_OVERFLOW_FLAGS_EN
            n_checks++;
            if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin
                n_fail++;
                $display("[TB] FAIL random_sticky[%0d]: got %b expected %b", i,
                         {overflow, underflow}, {exp_ovf, exp_unf});
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        while (model_q.size() < 5) step(1'b1, 1'b0, DATA_WIDTH'($urandom));
        while (model_q.size() > 5) step(1'b0, 1'b1, '0);
        n_checks++;
        if (fill_level !== 4'd5) begin
            n_fail++;
            $display("[TB] FAIL mid_pre_level: got %0d expected 5", fill_level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_status() !== model_status() || read_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got status=%b data=%h expected status=%b data=00",
                     dut_status(), read_data, model_status());
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b1, '0);
        n_checks++;
        if (read_data !== 8'hA5 || read_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_after: got data=%h empty=%b expected data=a5 empty=1", read_data, read_empty);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wraparound();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
